serial_sub: RTL and testbench

//   Bit-serial two's-complement subtractor: the inverse-direction companion of the
//   lab's ripple adder. Latches operands A and B, computes A - B one bit per clock
//   (LSB first) through a single full-subtractor cell and a borrow flip-flop.

---
 rtl/serial_sub.sv | 140 ++++++++++++++
 tb/tb_serial_sub.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor.
//
// On an accepted start, A and B are latched and A - B is formed one bit per clock, LSB
// first, through a single full-subtractor cell and a borrow flip-flop. After WIDTH shift
// cycles the difference and the final borrow are published. A one-cycle DONE state then
// returns the block to IDLE.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; sampled only while idle
//   a      minuend, captured on the accepting edge
//   b      subtrahend, captured on the accepting edge
//   busy   high in SHIFT and DONE
//   done   one-cycle pulse while in DONE
//   diff   (A - B) mod 2^WIDTH; held until the next result is published
//   bout   final borrow (A < B unsigned); held like diff
module serial_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic accept;
  logic last_shift;
  logic d_bit;
  logic borrow_nxt;

  assign accept     = (state_q == StIdle) && start;
  assign last_shift = (state_q == StShift) && (cnt_q == CntLast);

  // Full-subtractor cell on the current LSBs.
  assign d_bit      = sa_q[0] ^ sb_q[0] ^ borrow_q;
  assign borrow_nxt = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CntLast) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    diff = diff_q;
    bout = bout_q;
  end

  // Datapath next-state
  always_comb begin
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    if (accept) begin
      sa_d     = a;
      sb_d     = b;
      res_d    = '0;
      borrow_d = 1'b0;
      cnt_d    = '0;
    end else if (state_q == StShift) begin
      sa_d     = {1'b0, sa_q[WIDTH-1:1]};
      sb_d     = {1'b0, sb_q[WIDTH-1:1]};
      // New bit enters at the MSB; after WIDTH shifts bit i lands at position i.
      res_d    = {d_bit, res_q[WIDTH-1:1]};
      borrow_d = borrow_nxt;
      cnt_d    = cnt_q + CntW'(1);
    end

    // Publish on the DONE-entry edge, including the bit being formed on that edge.
    if (last_shift) begin
      diff_d = res_d;
      bout_d = borrow_nxt;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start2, busy2, done2, bout2;
  logic [1:0] a2, b2, diff2;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  serial_sub #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .busy  (busy2),
    .done  (done2),
    .diff  (diff2),
    .bout  (bout2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int dones8   = 0;
  int dones2   = 0;

  // Scoreboards of expected {bout, diff}
  logic [8:0] exp_q8[$];
  logic [2:0] exp_q2[$];
  logic [8:0] last8;
  logic [2:0] last2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else n_pass++;
  endtask

  // Output monitor: every done pulse must match the head of its scoreboard.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      dones8++;
      if (exp_q8.size() == 0) begin
        n_checks++;
        $display("FAIL dut8 unexpected done: got %0h, want no pulse", {bout8, diff8});
      end else begin
        check("dut8 result", {bout8, diff8}, exp_q8.pop_front());
      end
    end
    if (rst_n && done2) begin
      dones2++;
      if (exp_q2.size() == 0) begin
        n_checks++;
        $display("FAIL dut2 unexpected done: got %0h, want no pulse", {bout2, diff2});
      end else begin
        check("dut2 result", {bout2, diff2}, exp_q2.pop_front());
      end
    end
  end

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] expv,
                     input string tag);
    int n;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    exp_q8.push_back(expv);
    n = 1;
    check({tag, " busy"}, busy8, 1'b1);
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 4) check({tag, " hold"}, {bout8, diff8}, last8);
    end
    check({tag, " latency"}, n, 9);
    @(negedge clk);
    check({tag, " idle"}, busy8, 1'b0);
    last8 = expv;
  endtask

  task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic [2:0] expv);
    int n;
    @(negedge clk);
    a2 = av; b2 = bv; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    exp_q2.push_back(expv);
    n = 1;
    while (!done2 && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 2) check("w2 hold", {bout2, diff2}, last2);
    end
    check("w2 latency", n, 3);
    @(negedge clk);
    check("w2 idle", busy2, 1'b0);
    last2 = expv;
  endtask

  initial begin
    int n, m, d0;
    logic [7:0] ra, rb;
    logic [1:0] xa, xb;

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hC3, 8'hC3, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[6] = '{8'h01, 8'h80, 8'h81, 1'b1};

    start8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    last8 = '0; last2 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", busy8, 1'b0);
    check("reset done", done8, 1'b0);
    check("reset diff", diff8, 8'h00);
    check("reset bout", bout8, 1'b0);
    check("reset w2 busy", busy2, 1'b0);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      op8(vecs[i].a, vecs[i].b, {vecs[i].bout, vecs[i].diff}, "table");
    end

    // start during SHIFT is ignored
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    exp_q8.push_back(9'h00F);
    d0 = dones8;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 4;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ignore latency", n, 9);
    repeat (14) @(negedge clk);
    check("ignore done count", dones8 - d0, 1);
    check("ignore queue empty", exp_q8.size(), 0);
    last8 = 9'h00F;

    // start held high: back-to-back every WIDTH+2 cycles
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h80;
    exp_q8.push_back(9'h07F);
    exp_q8.push_back(9'h181);
    n = 1;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("b2b first latency", n, 9);
    last8 = 9'h07F;
    m = 0;
    do begin
      @(negedge clk);
      m++;
      if (m == 1) check("b2b idle gap", busy8, 1'b0);
      if (m == 2) start8 = 1'b0;
      if (m == 5) check("b2b hold", {bout8, diff8}, last8);
    end while (!done8 && m < 30);
    check("b2b period", m, 10);
    last8 = 9'h181;
    repeat (3) @(negedge clk);

    // Reset mid-SHIFT aborts
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0A; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    exp_q8.push_back(9'h04B);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy8, 1'b0);
    check("abort done", done8, 1'b0);
    check("abort diff", diff8, 8'h00);
    check("abort bout", bout8, 1'b0);
    exp_q8.delete();
    last8 = '0;
    d0 = dones8;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort no done", dones8 - d0, 0);
    check("abort idle", busy8, 1'b0);
    op8(8'h03, 8'h05, 9'h1FE, "post-reset");

    // Random operations against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(ra, rb, {1'b0, ra} - {1'b0, rb}, "rand");
    end

    // WIDTH=2 exhaustive
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        xa = 2'(i);
        xb = 2'(j);
        op2(xa, xb, {1'b0, xa} - {1'b0, xb});
      end
    end

    repeat (3) @(negedge clk);
    check("final queue8 empty", exp_q8.size(), 0);
    check("final queue2 empty", exp_q2.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
